// File: rtl/fc_auto_align_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : fc_auto_align_decoder
//  Purpose  : Deserialises the 320 Mb/s fast-command line, hunts for the IDLE
//             byte (F0) to find the byte phase, then decodes each aligned
//             byte into a one-hot command pulse. A manual-phase override
//             bypasses the hunt. Lock/unlock hysteresis and a saturating
//             invalid-frame counter are included.
//  Ports    : clk320        - 320 MHz clock, rising edge
//             rstn          - asynchronous active-low reset
//             fc            - serial fast command, MSB of each byte first
//             manual_en     - 1 = use manual_phase and skip the search
//             manual_phase  - byte phase used while manual_en = 1
//             err_clr       - synchronous clear of err_cnt (wins over +1)
//             fcd           - one-hot command pulse, one cycle wide
//             frame_strobe  - pulses with every decoded frame
//             locked        - high in LOCKED and MANUAL
//             bit_phase     - byte phase currently in use
//             err_cnt       - saturating invalid-frame count
//  Revision : 1.0 - initial release
// ============================================================================
module fc_auto_align_decoder #(
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk320,
    input  logic             rstn,
    input  logic             fc,
    input  logic             manual_en,
    input  logic [2:0]       manual_phase,
    input  logic             err_clr,
    output logic [9:0]       fcd,
    output logic             frame_strobe,
    output logic             locked,
    output logic [2:0]       bit_phase,
    output logic [ERR_W-1:0] err_cnt
);

    localparam logic [7:0] C_IDLE       = 8'hF0;
    localparam logic [4:0] C_LOCK_CNT   = 5'(LOCK_CNT);
    localparam logic [4:0] C_UNLOCK_CNT = 5'(UNLOCK_CNT);

    typedef enum logic [1:0] {
        ST_SEARCH  = 2'd0,
        ST_CONFIRM = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_MANUAL  = 2'd3
    } state_t;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    state_t           r_state;
    logic [7:0]       r_sr;
    logic [2:0]       r_bitcnt;
    logic [2:0]       r_phase;
    logic [3:0]       r_match_cnt;
    logic [3:0]       r_bad_cnt;
    logic [9:0]       r_fcd;
    logic             r_frame_strobe;
    logic [ERR_W-1:0] r_err_cnt;

    // ------------------------------------------------------------------
    // Combinational next values
    // ------------------------------------------------------------------
    state_t           w_state_nxt;
    logic [2:0]       w_phase_nxt;
    logic [3:0]       w_match_nxt;
    logic [3:0]       w_bad_nxt;
    logic [9:0]       w_fcd_nxt;
    logic             w_strobe_nxt;
    logic             w_err_inc;
    logic [ERR_W-1:0] w_err_nxt;

    logic             w_boundary;
    logic             w_is_idle;
    logic             w_decode_en;
    logic [9:0]       w_code_onehot;
    logic             w_code_valid;
    logic [4:0]       w_match_inc;
    logic [4:0]       w_bad_inc;

    // The byte currently in sr is complete when bitcnt equals the phase
    // captured at the IDLE match.
    assign w_boundary  = (r_bitcnt == r_phase);
    assign w_is_idle   = (r_sr == C_IDLE);
    assign w_decode_en = w_boundary &&
                         ((r_state == ST_LOCKED) || (r_state == ST_MANUAL));
    assign w_match_inc = {1'b0, r_match_cnt} + 5'd1;
    assign w_bad_inc   = {1'b0, r_bad_cnt} + 5'd1;

    // Command table -> one-hot bit position
    always_comb begin
        w_code_onehot = 10'd0;
        w_code_valid  = 1'b1;
        case (r_sr)
            8'hF0:   w_code_onehot = 10'b00_0000_0001; // IDLE
            8'hF8:   w_code_onehot = 10'b00_0000_0010; // LinkReset
            8'hF1:   w_code_onehot = 10'b00_0000_0100; // BCR
            8'hF2:   w_code_onehot = 10'b00_0000_1000; // SyncForTrig
            8'hF9:   w_code_onehot = 10'b00_0001_0000; // L1A_CR
            8'hF4:   w_code_onehot = 10'b00_0010_0000; // ChargeInj
            8'hF6:   w_code_onehot = 10'b00_0100_0000; // L1A
            8'hF3:   w_code_onehot = 10'b00_1000_0000; // L1A_BCR
            8'hFC:   w_code_onehot = 10'b01_0000_0000; // WS_Start
            8'hFA:   w_code_onehot = 10'b10_0000_0000; // WS_Stop
            default: w_code_valid  = 1'b0;
        endcase
    end

    // Next-state and registered-output logic
    always_comb begin
        w_state_nxt  = r_state;
        w_phase_nxt  = r_phase;
        w_match_nxt  = r_match_cnt;
        w_bad_nxt    = r_bad_cnt;
        w_fcd_nxt    = 10'd0;
        w_strobe_nxt = 1'b0;
        w_err_inc    = 1'b0;

        // Decode happens from the state held during the boundary cycle;
        // a state change decided at that same edge does not suppress it.
        if (w_decode_en) begin
            w_strobe_nxt = 1'b1;
            if (w_code_valid) begin
                w_fcd_nxt = w_code_onehot;
            end else begin
                w_err_inc = 1'b1;
            end
        end

        if (manual_en) begin
            // Override from any state; phase follows the input every cycle.
            w_state_nxt = ST_MANUAL;
            w_phase_nxt = manual_phase;
            w_match_nxt = 4'd0;
            w_bad_nxt   = 4'd0;
        end else begin
            case (r_state)
                ST_SEARCH: begin
                    // Sliding compare every cycle; the cycle of the match
                    // defines the byte phase.
                    if (w_is_idle) begin
                        w_phase_nxt = r_bitcnt;
                        w_match_nxt = 4'd1;
                        w_bad_nxt   = 4'd0;
                        w_state_nxt = (LOCK_CNT <= 1) ? ST_LOCKED : ST_CONFIRM;
                    end
                end
                ST_CONFIRM: begin
                    if (w_boundary) begin
                        if (w_is_idle) begin
                            w_match_nxt = r_match_cnt + 4'd1;
                            if (w_match_inc >= C_LOCK_CNT) begin
                                w_state_nxt = ST_LOCKED;
                                w_bad_nxt   = 4'd0;
                            end
                        end else begin
                            w_state_nxt = ST_SEARCH;
                            w_match_nxt = 4'd0;
                        end
                    end
                end
                ST_LOCKED: begin
                    if (w_boundary) begin
                        if (w_code_valid) begin
                            w_bad_nxt = 4'd0;
                        end else begin
                            w_bad_nxt = r_bad_cnt + 4'd1;
                            if (w_bad_inc >= C_UNLOCK_CNT) begin
                                w_state_nxt = ST_SEARCH;
                                w_bad_nxt   = 4'd0;
                                w_match_nxt = 4'd0;
                            end
                        end
                    end
                end
                ST_MANUAL: begin
                    // manual_en has fallen: restart the hunt
                    w_state_nxt = ST_SEARCH;
                    w_match_nxt = 4'd0;
                    w_bad_nxt   = 4'd0;
                end
                default: begin
                    w_state_nxt = ST_SEARCH;
                end
            endcase
        end
    end

    // Clear wins over a simultaneous increment; increment stops at all-ones.
    always_comb begin
        w_err_nxt = r_err_cnt;
        if (err_clr) begin
            w_err_nxt = '0;
        end else if (w_err_inc && !(&r_err_cnt)) begin
            w_err_nxt = r_err_cnt + ERR_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // State and data registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn) begin
            r_state <= ST_SEARCH;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk320 or negedge rstn) begin
        if (!rstn) begin
            r_sr           <= 8'd0;
            r_bitcnt       <= 3'd0;
            r_phase        <= 3'd0;
            r_match_cnt    <= 4'd0;
            r_bad_cnt      <= 4'd0;
            r_fcd          <= 10'd0;
            r_frame_strobe <= 1'b0;
            r_err_cnt      <= '0;
        end else begin
            r_sr           <= {r_sr[6:0], fc};
            r_bitcnt       <= r_bitcnt + 3'd1;
            r_phase        <= w_phase_nxt;
            r_match_cnt    <= w_match_nxt;
            r_bad_cnt      <= w_bad_nxt;
            r_fcd          <= w_fcd_nxt;
            r_frame_strobe <= w_strobe_nxt;
            r_err_cnt      <= w_err_nxt;
        end
    end

    assign fcd          = r_fcd;
    assign frame_strobe = r_frame_strobe;
    assign locked       = (r_state == ST_LOCKED) || (r_state == ST_MANUAL);
    assign bit_phase    = r_phase;
    assign err_cnt      = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_fc_auto_align_decoder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fc_auto_align_decoder
//  Purpose  : Self-checking bench for fc_auto_align_decoder. A behavioural
//             model (command table lookup, integer mode/counters) predicts
//             every output each cycle; directed checks cover lock timing,
//             decode, unlock, manual mode, saturation and async reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_auto_align_decoder;

    localparam int LOCK_N   = 4;
    localparam int UNLOCK_N = 4;
    localparam int ERR_MAX  = 255;

    localparam int MD_SEARCH  = 0;
    localparam int MD_CONFIRM = 1;
    localparam int MD_LOCKED  = 2;
    localparam int MD_MANUAL  = 3;

    logic       clk320       = 1'b0;
    logic       rstn         = 1'b0;
    logic       fc           = 1'b0;
    logic       manual_en    = 1'b0;
    logic [2:0] manual_phase = 3'd0;
    logic       err_clr      = 1'b0;
    logic [9:0] fcd;
    logic       frame_strobe;
    logic       locked;
    logic [2:0] bit_phase;
    logic [7:0] err_cnt;

    always #1.5 clk320 = ~clk320;

    fc_auto_align_decoder #(
        .LOCK_CNT   (LOCK_N),
        .UNLOCK_CNT (UNLOCK_N),
        .ERR_W      (8)
    ) dut (
        .clk320       (clk320),
        .rstn         (rstn),
        .fc           (fc),
        .manual_en    (manual_en),
        .manual_phase (manual_phase),
        .err_clr      (err_clr),
        .fcd          (fcd),
        .frame_strobe (frame_strobe),
        .locked       (locked),
        .bit_phase    (bit_phase),
        .err_cnt      (err_cnt)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [7:0] codes [10] = '{8'hF0, 8'hF8, 8'hF1, 8'hF2, 8'hF9,
                               8'hF4, 8'hF6, 8'hF3, 8'hFC, 8'hFA};
    logic [7:0] m_sr;
    int         m_cyc, m_phase, m_mode, m_match, m_bad, m_err;
    logic [9:0] m_fcd;
    logic       m_strobe;

    function automatic int lookup(input logic [7:0] v);
        for (int i = 0; i < 10; i++) begin
            if (codes[i] == v) return i;
        end
        return -1;
    endfunction

    function automatic logic m_locked();
        return (m_mode == MD_LOCKED) || (m_mode == MD_MANUAL);
    endfunction

    task automatic model_reset();
        m_sr = 8'd0; m_cyc = 0; m_phase = 0; m_mode = MD_SEARCH;
        m_match = 0; m_bad = 0; m_err = 0; m_fcd = 10'd0; m_strobe = 1'b0;
    endtask

    task automatic model_step(input logic b, input logic men, input logic [2:0] mph, input logic clr);
        bit at_frame;
        bit bump;
        int idx;
        at_frame = (m_cyc == m_phase);
        idx      = lookup(m_sr);
        bump     = 1'b0;
        m_fcd    = 10'd0;
        m_strobe = 1'b0;
        if (at_frame && m_locked()) begin
            m_strobe = 1'b1;
            if (idx >= 0) m_fcd = 10'd1 << idx;
            else          bump  = 1'b1;
        end
        if (men) begin
            m_mode = MD_MANUAL; m_phase = int'(mph); m_match = 0; m_bad = 0;
        end else if (m_mode == MD_MANUAL) begin
            m_mode = MD_SEARCH; m_match = 0; m_bad = 0;
        end else if (m_mode == MD_SEARCH) begin
            if (m_sr == 8'hF0) begin
                m_phase = m_cyc; m_match = 1; m_bad = 0;
                m_mode  = (LOCK_N == 1) ? MD_LOCKED : MD_CONFIRM;
            end
        end else if (m_mode == MD_CONFIRM) begin
            if (at_frame) begin
                if (m_sr == 8'hF0) begin
                    m_match++;
                    if (m_match >= LOCK_N) begin m_mode = MD_LOCKED; m_bad = 0; end
                end else begin
                    m_mode = MD_SEARCH; m_match = 0;
                end
            end
        end else begin
            if (at_frame) begin
                if (idx >= 0) m_bad = 0;
                else begin
                    m_bad++;
                    if (m_bad >= UNLOCK_N) begin m_mode = MD_SEARCH; m_bad = 0; m_match = 0; end
                end
            end
        end
        if (clr)                         m_err = 0;
        else if (bump && m_err < ERR_MAX) m_err++;
        m_sr  = {m_sr[6:0], b};
        m_cyc = (m_cyc + 1) % 8;
    endtask

    // ------------------------------------------------------------------
    // Stimulus helpers (entered and left on a falling edge)
    // ------------------------------------------------------------------
    logic [9:0] seen_fcd = 10'd0;
    bit         rand_clr = 1'b0;

    task automatic cycle(input logic b);
        fc = b;
        if (rand_clr) err_clr = ($urandom_range(0, 99) < 3);
        @(posedge clk320);
        if (rstn) model_step(b, manual_en, manual_phase, err_clr);
        else      model_reset();
        @(negedge clk320);
        check("cyc", {9'd0, fcd, frame_strobe, locked, bit_phase, err_cnt},
              {9'd0, m_fcd, m_strobe, m_locked(), 3'(m_phase), 8'(m_err)});
        seen_fcd = seen_fcd | fcd;
    endtask

    task automatic send_bits(input logic [7:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) cycle(v[i]);
    endtask

    task automatic send_byte(input logic [7:0] v);
        send_bits(v, 8);
    endtask

    // Three frames of one code; captures the pulses of the first two.
    task automatic burst(input int idx);
        logic [7:0] c;
        c = codes[idx];
        send_bits({7'd0, c[7]}, 1);
        seen_fcd = 10'd0;
        send_bits(c, 7);
        send_byte(c);
        send_byte(c);
        check($sformatf("dec_fcd_%0d", idx), 32'(seen_fcd), 32'(1) << idx);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_fcd"},    32'(fcd),          32'd0);
        check({tag, "_strobe"}, 32'(frame_strobe), 32'd0);
        check({tag, "_locked"}, 32'(locked),       32'd0);
        check({tag, "_phase"},  32'(bit_phase),    32'd0);
        check({tag, "_err"},    32'(err_cnt),      32'd0);
    endtask

    int k;
    int j;
    int order [10];

    initial begin
        model_reset();
        @(negedge clk320);

        // Reset held with random line activity
        for (int i = 0; i < 10; i++) cycle(1'($urandom_range(0, 1)));
        check_all_zero("rst");

        // Release, offset the stream by k bits, lock on IDLE
        rstn = 1'b1;
        k = $urandom_range(1, 7);
        send_bits(8'd0, k);
        repeat (3) send_byte(8'hF0);
        send_bits(8'h01, 1);
        check("lock_after3", 32'(locked), 32'd0);
        send_bits(8'h70, 7);
        send_bits(8'h01, 1);
        check("lock_after4", 32'(locked), 32'd1);
        check("lock_phase", 32'(bit_phase), 32'(k));
        send_bits(8'h70, 7);

        // Every code, in random order
        for (int i = 0; i < 10; i++) order[i] = i;
        for (int i = 9; i > 0; i--) begin
            int r;
            int t;
            r = $urandom_range(0, i);
            t = order[i]; order[i] = order[r]; order[r] = t;
        end
        for (int i = 0; i < 10; i++) burst(order[i]);
        check("dec_err", 32'(err_cnt), 32'd0);

        // Corruption below the unlock threshold, then enough to unlock
        repeat (3) send_byte(8'h00);
        send_byte(8'hF0);
        send_bits(8'h00, 1);
        check("corr_err3", 32'(err_cnt), 32'd3);
        check("corr_locked", 32'(locked), 32'd1);
        send_bits(8'h00, 7);
        repeat (3) send_byte(8'h00);
        send_bits(8'h01, 1);
        check("unlock_locked", 32'(locked), 32'd0);
        check("unlock_err7", 32'(err_cnt), 32'd7);
        send_bits(8'h70, 7);
        repeat (4) send_byte(8'hF0);
        send_bits(8'h01, 1);
        check("relock", 32'(locked), 32'd1);
        check("relock_phase", 32'(bit_phase), 32'(k));
        send_bits(8'h70, 7);

        // Random mix of valid and random bytes with sporadic clears
        rand_clr = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 3) != 0) send_byte(codes[$urandom_range(0, 9)]);
            else                           send_byte(8'($urandom));
        end
        rand_clr = 1'b0;
        err_clr  = 1'b0;

        // Manual mode: shift the stream so its bytes end at phase 2
        j = (2 - k + 8) % 8;
        if (j != 0) send_bits(8'd0, j);
        manual_en    = 1'b1;
        manual_phase = 3'd2;
        send_bits(8'h01, 1);
        check("man_locked", 32'(locked), 32'd1);
        check("man_phase", 32'(bit_phase), 32'd2);
        send_bits(8'h70, 7);
        send_byte(8'hF0);
        err_clr = 1'b1;
        send_bits(8'h01, 1);
        err_clr = 1'b0;
        check("man_clr", 32'(err_cnt), 32'd0);
        send_bits(8'h70, 7);
        burst(6);
        burst(8);
        check("man_dec_err", 32'(err_cnt), 32'd0);

        // Wrong manual phase: every frame invalid, never unlocks
        manual_phase = 3'd3;
        repeat (10) send_byte(8'hF0);
        check("man_bad_locked", 32'(locked), 32'd1);
        repeat (300) send_byte(8'hF0);
        check("sat_err", 32'(err_cnt), 32'd255);
        err_clr = 1'b1;
        send_byte(8'hF0);
        err_clr = 1'b0;
        check("sat_clr", 32'(err_cnt), 32'd0);
        send_byte(8'hF0);
        check("after_clr", 32'(err_cnt), 32'd1);

        // Leave manual: search restarts
        manual_en = 1'b0;
        send_bits(8'h01, 1);
        check("man_exit", 32'(locked), 32'd0);
        send_bits(8'h70, 7);
        repeat (6) send_byte(8'hF0);
        check("exit_relock", 32'(locked), 32'd1);

        // 100 ps reset pulse between clock edges
        #0.5;
        rstn = 1'b0;
        #0.05;
        model_reset();
        check_all_zero("async");
        #0.05;
        rstn = 1'b1;
        repeat (3) send_byte(8'hF0);
        send_bits(8'h01, 1);
        check("async_lock3", 32'(locked), 32'd0);
        send_bits(8'h70, 7);
        send_bits(8'h01, 1);
        check("async_lock4", 32'(locked), 32'd1);
        check("async_phase", 32'(bit_phase), 32'd0);
        send_bits(8'h70, 7);
        burst(1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
